// File: rtl/byte_stream_ctrl.sv
// Frame sequencer for an MSB-first serial-to-parallel streamer: gates shifting,
// counts bits/words and captures each completed word into a valid/ready holding register.
module byte_stream_ctrl #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned FRAME_BYTES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             bit_valid,
   output logic             shift_enable,
   input  logic [WIDTH-1:0] parallel_in,
   output logic [WIDTH-1:0] byte_out,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic             byte_last,
   output logic             busy,
   output logic             overrun
);

   localparam int unsigned BIT_CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned BYTE_CW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(WIDTH - 1);
   localparam logic [BYTE_CW-1:0] BYTE_LAST = BYTE_CW'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2
   } state_e;

   state_e               state_q;
   logic [BIT_CW-1:0]    bit_cnt_q;
   logic [BYTE_CW-1:0]   byte_cnt_q;
   logic                 cap_pend_q;
   logic                 cap_last_q;
   logic [WIDTH-1:0]     byte_out_q;
   logic                 byte_valid_q;
   logic                 byte_last_q;
   logic                 overrun_q;

   // The streamer shifts in the same cycle the bit is presented.
   assign shift_enable = (state_q == SHIFT) && bit_valid;
   assign busy         = (state_q != IDLE);
   assign byte_out     = byte_out_q;
   assign byte_valid   = byte_valid_q;
   assign byte_last    = byte_last_q;
   assign overrun      = overrun_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         cap_pend_q   <= 1'b0;
         cap_last_q   <= 1'b0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         byte_last_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         cap_pend_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (frame_start) begin
                  state_q    <= SHIFT;
                  bit_cnt_q  <= '0;
                  byte_cnt_q <= '0;
                  overrun_q  <= 1'b0;
               end
            end
            SHIFT: begin
               if (shift_enable) begin
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_q  <= '0;
                     cap_pend_q <= 1'b1;
                     cap_last_q <= (byte_cnt_q == BYTE_LAST);
                     if (byte_cnt_q == BYTE_LAST) begin
                        state_q <= FLUSH;
                     end else begin
                        byte_cnt_q <= byte_cnt_q + BYTE_CW'(1);
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BIT_CW'(1);
                  end
               end
            end
            FLUSH: begin
               if (!cap_pend_q && (!byte_valid_q || byte_ready)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Capture one cycle after the word completes; a pop frees the slot in the same cycle.
         if (cap_pend_q) begin
            if (!byte_valid_q || byte_ready) begin
               byte_out_q   <= parallel_in;
               byte_valid_q <= 1'b1;
               byte_last_q  <= cap_last_q;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (byte_valid_q && byte_ready) begin
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
         end
      end
   end

endmodule

// File: doc/byte_stream_ctrl.md
Name: byte_stream_ctrl

Overview:
- Sequences the 8-bit serial-to-parallel shift register (ByteStreamer) over a frame of FRAME_BYTES bytes.
- Gates its shift_enable from an incoming bit-valid strobe and counts bits.
- Captures each completed word from the streamer's parallel output into a one-entry valid/ready holding register, tags the last byte of the frame and flags overruns.
- Sits between the serial front end and the byte-wide consumer.

Parameters:
- WIDTH, 8, bits per word; must equal the streamer width.
- FRAME_BYTES, 4, words per frame (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse that opens a frame; accepted only in IDLE
- bit_valid  in  1  the serial bit presented to the streamer is valid this cycle
- shift_enable  out  WIDTH-independent 1  drives the streamer's shift_enable
- parallel_in  in  WIDTH  streamer's parallel_out
- byte_out  out  WIDTH  captured word
- byte_valid  out  1  byte_out holds a word
- byte_ready  in  1  consumer accepts byte_out when byte_valid && byte_ready
- byte_last  out  1  qualifies byte_out as the final word of the frame
- busy  out  1  high in any state other than IDLE
- overrun  out  1  sticky; a completed word was dropped because the holding register was full

Behaviour:
- Reset (rst=1 at a rising edge, any state, including mid-frame):
  - state=IDLE; bit_cnt, byte_cnt and cap_pend cleared.
  - byte_out=0, byte_valid=0, byte_last=0, overrun=0, busy=0.
  - Streamer contents are not cleared; stale bits are fully overwritten by the next 8 shifts.
- States:
  - IDLE: shift_enable=0; bit_valid ignored. frame_start=1 -> SHIFT, bit_cnt=0, byte_cnt=0, overrun cleared.
  - SHIFT: shift_enable = bit_valid (combinational, no registering).
    - Each enabled cycle increments bit_cnt.
    - On an enabled cycle with bit_cnt==WIDTH-1: bit_cnt wraps to 0 and cap_pend is set for the next cycle.
    - If that word is byte_cnt==FRAME_BYTES-1, go to FLUSH; otherwise increment byte_cnt.
  - FLUSH: shift_enable=0; bit_valid ignored. Go to IDLE when cap_pend==0 and (byte_valid==0 or byte_ready==1).
- frame_start outside IDLE is ignored and has no side effects.
- Capture timing:
  - Let edge E be the edge that clocks the last bit of a word into the streamer. In the cycle after E, parallel_in holds the complete word; the holding register loads at edge E+1.
  - byte_valid is therefore high from E+1, a latency of one cycle after the word completes.
  - Shifting may continue during the capture cycle: the streamer updates only at E+1, after sampling, so no bits are lost at full bit rate.
- Holding register:
  - Capture succeeds if byte_valid==0, or if byte_valid && byte_ready in the capture cycle (simultaneous pop and load; back-to-back valid, no bubble).
  - On success: byte_out=parallel_in, byte_valid=1, byte_last=1 iff the word is the frame's final word.
  - Otherwise the new word is dropped, overrun=1, and byte_out/byte_valid/byte_last are unchanged.
  - A handshake with no capture: byte_valid=0, byte_last=0; byte_out is held.
  - byte_out must not change while byte_valid=1 and byte_ready=0.
- overrun stays set until rst or the next accepted frame_start. A dropped final word means byte_last never asserts for that frame; FLUSH still exits per the rule above.
- Bit order is MSB-first, as set by the streamer: the first bit of a word appears in byte_out[WIDTH-1].
- Counter widths: bit_cnt=clog2(WIDTH); byte_cnt=max(1,clog2(FRAME_BYTES)). No other arithmetic.

Test Plan:
The bench instantiates the 8-bit streamer model with default parameters.
1. Reset: rst=1 for 2 cycles mid-SHIFT after 5 bits -> next cycle all outputs 0 and busy=0; a new frame_start then yields correct bytes (stale bits flushed).
2. Full-rate frame: frame_start, then 32 consecutive valid bits for 0xA5,0x3C,0xFF,0x00 with byte_ready=1 -> four byte_valid pulses with exactly those values, each 1 cycle after its 8th bit. byte_last only on 0x00, overrun=0, busy drops the cycle after the last handshake.
3. Gapped bits: bit_valid toggling 1,0,0,1,... over the same frame -> shift_enable mirrors bit_valid; identical byte sequence.
4. Backpressure/overrun: byte_ready=0 through the first 16 bits (0xA5,0x3C) -> byte_out=0xA5 held stable and overrun=1 after the second capture; raise ready -> 0xA5 accepted and 0x3C never appears.
5. Simultaneous pop and capture: byte_ready asserted exactly in the capture cycle of byte 2 while byte 1 is valid -> byte_valid stays high across the boundary, byte_out changes 0xA5->0x3C, overrun=0.
6. frame_start pulsed during SHIFT and FLUSH -> ignored: byte_cnt, overrun and output sequence unaffected; FLUSH with byte_ready=0 holds busy=1 until ready.
